// File: rtl/lv_hv_shadow_poll_ctrl.sv
// ============================================================================
// lv_hv_shadow_poll_ctrl
// ----------------------------------------------------------------------------
// LV-side poll scheduler. It sweeps the seven HV shadow-register addresses
// and issues an OWT read command for each one. It then waits for the matching
// response on the OWT RX bus, retrying failed reads, and flags HV comms
// failure once per sweep.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_poll_en           level, enables periodic sweeps
//   i_sweep_force       pulse, requests a sweep as soon as the block is idle
//   o_owt_tx_req/cmd    read-command request towards OWT TX, {1'b0, addr}
//   i_owt_tx_ack        OWT TX accepted the command this cycle
//   i_owt_rx_ack/cmd/   OWT RX response valid, response command (MSB = response
//   i_owt_rx_status       flag, low bits = address), status (1 = error)
//   o_busy              sweep in progress
//   o_cur_idx           current address-table index (meaningful while busy)
//   o_sweep_done        one-cycle pulse when a sweep finishes
//   o_hv_comm_err       set at sweep end if any address exhausted its retries
//   o_err_cnt           saturating count of addresses that exhausted retries
// ============================================================================
module lv_hv_shadow_poll_ctrl #(
   parameter int OWT_CMD_BIT_NUM   = 8,
   parameter int REG_AW            = 7,
   parameter int POLL_INTERVAL_CYC = 1000,
   parameter int RSP_TIMEOUT_CYC   = 256,
   parameter int MAX_RETRY         = 2,
   parameter int ERR_CNT_W         = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_poll_en,
   input  logic                       i_sweep_force,
   output logic                       o_owt_tx_req,
   output logic [OWT_CMD_BIT_NUM-1:0] o_owt_tx_cmd,
   input  logic                       i_owt_tx_ack,
   input  logic                       i_owt_rx_ack,
   input  logic [OWT_CMD_BIT_NUM-1:0] i_owt_rx_cmd,
   input  logic                       i_owt_rx_status,
   output logic                       o_busy,
   output logic [2:0]                 o_cur_idx,
   output logic                       o_sweep_done,
   output logic                       o_hv_comm_err,
   output logic [ERR_CNT_W-1:0]       o_err_cnt
);

   // Counters only ever reach (limit - 1), so clog2(limit) bits are enough.
   localparam int IVL_W  = $clog2(POLL_INTERVAL_CYC);
   localparam int TMO_W  = $clog2(RSP_TIMEOUT_CYC);
   localparam int RTRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [IVL_W-1:0]  IVL_LAST  = IVL_W'(POLL_INTERVAL_CYC - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(RSP_TIMEOUT_CYC - 1);
   localparam logic [RTRY_W-1:0] RTRY_MAX  = RTRY_W'(MAX_RETRY);
   localparam logic [2:0]        LAST_IDX  = 3'd6;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_RSP,
      NEXT
   } state_t;

   state_t                       state_q;
   logic [2:0]                   idx_q;
   logic [RTRY_W-1:0]            retryCnt_q;
   logic [TMO_W-1:0]             timer_q;
   logic [IVL_W-1:0]             ivlCnt_q;
   logic                         forcePend_q;
   logic                         sweepFail_q;
   logic                         txReq_q;
   logic [OWT_CMD_BIT_NUM-1:0]   txCmd_q;
   logic                         busy_q;
   logic                         sweepDone_q;
   logic                         commErr_q;
   logic [ERR_CNT_W-1:0]         errCnt_q;
   logic [ERR_CNT_W-1:0]         errCnt_d;
   logic                         startSweep;
   logic                         rspMatch;

   // Fixed shadow-register address table.
   function automatic logic [REG_AW-1:0] addrOf(input logic [2:0] idx);
      case (idx)
         3'd0:    addrOf = REG_AW'(7'h08);
         3'd1:    addrOf = REG_AW'(7'h0A);
         3'd2:    addrOf = REG_AW'(7'h0C);
         3'd3:    addrOf = REG_AW'(7'h0D);
         3'd4:    addrOf = REG_AW'(7'h14);
         3'd5:    addrOf = REG_AW'(7'h15);
         3'd6:    addrOf = REG_AW'(7'h1F);
         default: addrOf = '0;
      endcase
   endfunction

   // A pending force wins regardless of the interval counter; only meaningful in IDLE.
   assign startSweep = (i_poll_en && (ivlCnt_q == IVL_LAST)) || forcePend_q;

   // A good response must be flagged as a response, echo the address we asked for, and report no error.
   assign rspMatch = i_owt_rx_cmd[OWT_CMD_BIT_NUM-1]
                     && (i_owt_rx_cmd[REG_AW-1:0] == addrOf(idx_q))
                     && !i_owt_rx_status;

   // The error counter sticks at all-ones instead of wrapping.
   assign errCnt_d = (&errCnt_q) ? errCnt_q : errCnt_q + ERR_CNT_W'(1);

   // Sweep FSM with all outputs registered. The force request is latched at
   // the top so that pulses arriving mid-sweep collapse into one pending
   // sweep. The IDLE branch clears the latch when a sweep starts, which also
   // absorbs a pulse that lands on the start cycle itself.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         retryCnt_q  <= '0;
         timer_q     <= '0;
         ivlCnt_q    <= '0;
         forcePend_q <= 1'b0;
         sweepFail_q <= 1'b0;
         txReq_q     <= 1'b0;
         txCmd_q     <= '0;
         busy_q      <= 1'b0;
         sweepDone_q <= 1'b0;
         commErr_q   <= 1'b0;
         errCnt_q    <= '0;
      end else begin
         sweepDone_q <= 1'b0;
         if (i_sweep_force) begin
            forcePend_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (startSweep) begin
                  state_q     <= SEND;
                  busy_q      <= 1'b1;
                  txReq_q     <= 1'b1;
                  txCmd_q     <= {1'b0, addrOf(3'd0)};
                  idx_q       <= '0;
                  retryCnt_q  <= '0;
                  ivlCnt_q    <= '0;
                  forcePend_q <= 1'b0;
               end else if (i_poll_en) begin
                  ivlCnt_q <= ivlCnt_q + IVL_W'(1);
               end else begin
                  ivlCnt_q <= '0;
               end
            end
            SEND: begin
               if (i_owt_tx_ack) begin
                  state_q <= WAIT_RSP;
                  txReq_q <= 1'b0;
                  timer_q <= '0;
               end
            end
            WAIT_RSP: begin
               timer_q <= timer_q + TMO_W'(1);
               // A response arriving on the timeout cycle still decides the outcome.
               if (i_owt_rx_ack || (timer_q == TMO_LAST)) begin
                  if (i_owt_rx_ack && rspMatch) begin
                     state_q <= NEXT;
                  end else if (retryCnt_q < RTRY_MAX) begin
                     retryCnt_q <= retryCnt_q + RTRY_W'(1);
                     state_q    <= SEND;
                     txReq_q    <= 1'b1;
                  end else begin
                     errCnt_q    <= errCnt_d;
                     sweepFail_q <= 1'b1;
                     state_q     <= NEXT;
                  end
               end
            end
            NEXT: begin
               if (idx_q == LAST_IDX) begin
                  sweepDone_q <= 1'b1;
                  commErr_q   <= sweepFail_q;
                  sweepFail_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  idx_q      <= idx_q + 3'd1;
                  retryCnt_q <= '0;
                  txReq_q    <= 1'b1;
                  txCmd_q    <= {1'b0, addrOf(idx_q + 3'd1)};
                  state_q    <= SEND;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_owt_tx_req  = txReq_q;
   assign o_owt_tx_cmd  = txCmd_q;
   assign o_busy        = busy_q;
   assign o_cur_idx     = idx_q;
   assign o_sweep_done  = sweepDone_q;
   assign o_hv_comm_err = commErr_q;
   assign o_err_cnt     = errCnt_q;

endmodule

// File: tb/tb_lv_hv_shadow_poll_ctrl.sv
// ============================================================================
// tb_lv_hv_shadow_poll_ctrl
// ----------------------------------------------------------------------------
// Scoreboard bench. Stimulus builds a per-sweep response plan for every
// address and attempt. A reference model turns that plan into the expected
// command sequence and the expected end-of-sweep flags. An HV stub answers
// each command according to the plan, and a monitor checks what the DUT
// presents against the queued expectations.
// ============================================================================
module tb_lv_hv_shadow_poll_ctrl;

   localparam int CMD_W     = 8;
   localparam int AW        = 7;
   localparam int POLL_IVL  = 10;
   localparam int RSP_TO    = 8;
   localparam int MAX_RETRY = 2;
   localparam int ECW       = 2;
   localparam int ATTEMPTS  = MAX_RETRY + 1;
   localparam int ERR_MAX   = (1 << ECW) - 1;
   localparam int BUDGET    = 3000;

   typedef enum int {RSP_OK, RSP_LATE, RSP_STAT, RSP_ADDR, RSP_MSB, RSP_NONE} rsp_e;

   typedef struct {
      logic [CMD_W-1:0] cmd;
      int               idx;
   } cmdExp_t;

   typedef struct {
      rsp_e kind;
      int   idx;
   } rspPlan_t;

   typedef struct {
      logic           commErr;
      logic [ECW-1:0] errCnt;
   } doneExp_t;

   logic             clk;
   logic             rst;
   logic             pollEn;
   logic             sweepForce;
   logic             txReq;
   logic [CMD_W-1:0] txCmd;
   logic             txAck;
   logic             rxAck;
   logic [CMD_W-1:0] rxCmd;
   logic             rxStatus;
   logic             busy;
   logic [2:0]       curIdx;
   logic             sweepDone;
   logic             commErr;
   logic [ECW-1:0]   errCnt;

   logic [AW-1:0] addrTable [7] = '{7'h08, 7'h0A, 7'h0C, 7'h0D, 7'h14, 7'h15, 7'h1F};

   rsp_e     plan [7][ATTEMPTS];
   cmdExp_t  cmdQ[$];
   rspPlan_t rspQ[$];
   doneExp_t doneQ[$];
   int       startQ[$];

   int   checks = 0;
   int   errors = 0;
   int   mErrCnt = 0;
   int   hsCount = 0;
   int   doneCount = 0;
   int   expDone = 0;
   logic resetActive;

   lv_hv_shadow_poll_ctrl #(
      .OWT_CMD_BIT_NUM  (CMD_W),
      .REG_AW           (AW),
      .POLL_INTERVAL_CYC(POLL_IVL),
      .RSP_TIMEOUT_CYC  (RSP_TO),
      .MAX_RETRY        (MAX_RETRY),
      .ERR_CNT_W        (ECW)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_poll_en      (pollEn),
      .i_sweep_force  (sweepForce),
      .o_owt_tx_req   (txReq),
      .o_owt_tx_cmd   (txCmd),
      .i_owt_tx_ack   (txAck),
      .i_owt_rx_ack   (rxAck),
      .i_owt_rx_cmd   (rxCmd),
      .i_owt_rx_status(rxStatus),
      .o_busy         (busy),
      .o_cur_idx      (curIdx),
      .o_sweep_done   (sweepDone),
      .o_hv_comm_err  (commErr),
      .o_err_cnt      (errCnt)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point; every check in the bench funnels through here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Counts an event the model did not predict as a failed comparison.
   task automatic flagUnexpected(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: DUT produced an event with nothing expected", name);
   endtask

   // Reference model: each address is tried until a good answer or until all
   // attempts are used up. Exhausted addresses bump a saturating error count
   // and make the sweep report a comms error.
   task automatic queueSweep(input int gap);
      logic     anyFail;
      logic     ok;
      cmdExp_t  c;
      rspPlan_t r;
      doneExp_t d;
      anyFail = 1'b0;
      for (int a = 0; a < 7; a++) begin
         ok = 1'b0;
         for (int t = 0; t < ATTEMPTS; t++) begin
            if (!ok) begin
               c.cmd = {1'b0, addrTable[a]};
               c.idx = a;
               cmdQ.push_back(c);
               r.kind = plan[a][t];
               r.idx  = a;
               rspQ.push_back(r);
               if (plan[a][t] == RSP_OK || plan[a][t] == RSP_LATE) begin
                  ok = 1'b1;
               end
            end
         end
         if (!ok) begin
            anyFail = 1'b1;
            if (mErrCnt < ERR_MAX) begin
               mErrCnt++;
            end
         end
      end
      d.commErr = anyFail;
      d.errCnt  = ECW'(mErrCnt);
      doneQ.push_back(d);
      startQ.push_back(gap);
   endtask

   // Plan helpers: every attempt answered correctly, or a random mix of outcomes.
   task automatic setAllOk();
      for (int a = 0; a < 7; a++) begin
         for (int t = 0; t < ATTEMPTS; t++) begin
            plan[a][t] = RSP_OK;
         end
      end
   endtask

   task automatic randomPlan();
      int v;
      for (int a = 0; a < 7; a++) begin
         for (int t = 0; t < ATTEMPTS; t++) begin
            v = $urandom_range(0, 9);
            if (v <= 4)      plan[a][t] = RSP_OK;
            else if (v == 5) plan[a][t] = RSP_LATE;
            else if (v == 6) plan[a][t] = RSP_STAT;
            else if (v == 7) plan[a][t] = RSP_ADDR;
            else if (v == 8) plan[a][t] = RSP_MSB;
            else             plan[a][t] = RSP_NONE;
         end
      end
   endtask

   // One-cycle force pulse, driven just after a rising edge.
   task automatic pulseForce();
      @(posedge clk); #1;
      sweepForce = 1'b1;
      @(posedge clk); #1;
      sweepForce = 1'b0;
   endtask

   // Queue the model's view of a sweep, then kick it off with a force pulse.
   task automatic applyStimulus(input int gap);
      queueSweep(gap);
      pulseForce();
   endtask

   // Waits for the monitor to have seen the expected number of done pulses.
   task automatic waitDone(input int target);
      int n;
      n = 0;
      while (doneCount < target && n < BUDGET) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (doneCount < target) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_done: got %0d done pulses expected %0d within %0d cycles", doneCount, target, BUDGET);
      end
   endtask

   task automatic waitBusy();
      int n;
      n = 0;
      while (!busy && n < BUDGET) begin
         @(posedge clk); #1;
         n++;
      end
      if (!busy) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_busy: busy still 0 after %0d cycles", BUDGET);
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // HV stub: acknowledges each TX request after a random delay. It then
   // answers according to the next plan entry, a random 1..RSP_TO-1 cycles
   // later, or exactly on the timeout cycle for a late answer. A missing
   // answer is simply never sent.
   initial begin : responder
      rspPlan_t r;
      int       d;
      txAck    = 1'b0;
      rxAck    = 1'b0;
      rxCmd    = '0;
      rxStatus = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (!rst && txReq) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
            txAck = 1'b1;
            @(posedge clk); #1;
            txAck = 1'b0;
            if (rspQ.size() == 0) begin
               r.kind = RSP_NONE;
               r.idx  = 0;
            end else begin
               r = rspQ.pop_front();
            end
            if (r.kind != RSP_NONE) begin
               d = (r.kind == RSP_LATE) ? RSP_TO : $urandom_range(1, RSP_TO - 1);
               repeat (d - 1) begin
                  @(posedge clk); #1;
               end
               rxAck    = 1'b1;
               rxStatus = (r.kind == RSP_STAT);
               case (r.kind)
                  RSP_ADDR: rxCmd = {1'b1, addrTable[(r.idx + 1) % 7]};
                  RSP_MSB:  rxCmd = {1'b0, addrTable[r.idx]};
                  default:  rxCmd = {1'b1, addrTable[r.idx]};
               endcase
               @(posedge clk); #1;
               rxAck    = 1'b0;
               rxStatus = 1'b0;
               rxCmd    = '0;
            end
         end
      end
   end

   // Monitor: on the falling edge, pops and compares the expectation for
   // every accepted command, every done pulse and every sweep start.
   initial begin : monitor
      int       cycle;
      int       lastDone;
      logic     prevBusy;
      cmdExp_t  c;
      doneExp_t d;
      int       gap;
      cycle    = 0;
      lastDone = -1000;
      prevBusy = 1'b0;
      forever begin
         @(negedge clk);
         cycle++;
         if (!resetActive) begin
            if (txReq && txAck) begin
               hsCount++;
               if (cmdQ.size() == 0) begin
                  flagUnexpected("tx_cmd");
               end else begin
                  c = cmdQ.pop_front();
                  checkOutput("tx_cmd", 32'(txCmd), 32'(c.cmd));
                  checkOutput("cur_idx", 32'(curIdx), 32'(c.idx));
               end
            end
            if (sweepDone) begin
               doneCount++;
               lastDone = cycle;
               if (doneQ.size() == 0) begin
                  flagUnexpected("sweep_done");
               end else begin
                  d = doneQ.pop_front();
                  checkOutput("comm_err", 32'(commErr), 32'(d.commErr));
                  checkOutput("err_cnt", 32'(errCnt), 32'(d.errCnt));
                  checkOutput("busy_at_done", 32'(busy), 32'd0);
               end
            end
            if (busy && !prevBusy) begin
               if (startQ.size() == 0) begin
                  flagUnexpected("sweep_start");
               end else begin
                  gap = startQ.pop_front();
                  if (gap >= 0) begin
                     checkOutput("start_gap", 32'(cycle - lastDone), 32'(gap));
                  end
               end
            end
         end
         prevBusy = busy;
      end
   end

   // Directed scenarios first, then randomized sweeps, periodic mode,
   // forced-while-busy, saturation, and a reset in the middle of a sweep.
   initial begin : stimulus
      int hs0;
      rst         = 1'b1;
      resetActive = 1'b1;
      pollEn      = 1'b0;
      sweepForce  = 1'b0;
      idleCycles(3);
      checkOutput("rst_tx_req", 32'(txReq), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(sweepDone), 32'd0);
      checkOutput("rst_err_cnt", 32'(errCnt), 32'd0);
      rst = 1'b0;
      idleCycles(1);
      resetActive = 1'b0;
      mErrCnt     = 0;

      $display("[TB] clean forced sweep");
      setAllOk();
      applyStimulus(-1);
      waitDone(++expDone);
      idleCycles(5);

      $display("[TB] address 0x0C never answered");
      setAllOk();
      for (int t = 0; t < ATTEMPTS; t++) plan[2][t] = RSP_NONE;
      applyStimulus(-1);
      waitDone(++expDone);
      idleCycles(5);

      $display("[TB] clean sweep clears comm_err");
      setAllOk();
      applyStimulus(-1);
      waitDone(++expDone);
      idleCycles(5);

      $display("[TB] recoverable errors and late answer");
      setAllOk();
      plan[0][0] = RSP_ADDR;
      plan[1][0] = RSP_LATE;
      plan[3][0] = RSP_MSB;
      plan[4][0] = RSP_STAT;
      plan[6][0] = RSP_STAT;
      plan[6][1] = RSP_NONE;
      applyStimulus(-1);
      waitDone(++expDone);
      idleCycles(5);

      $display("[TB] periodic sweeps");
      randomPlan();
      queueSweep(-1);
      randomPlan();
      queueSweep(POLL_IVL);
      pollEn = 1'b1;
      waitDone(++expDone);
      waitBusy();
      pollEn = 1'b0;
      waitDone(++expDone);
      idleCycles(4 * POLL_IVL);

      $display("[TB] two force pulses during a sweep");
      randomPlan();
      queueSweep(-1);
      randomPlan();
      queueSweep(1);
      pulseForce();
      waitBusy();
      idleCycles(4);
      pulseForce();
      idleCycles(3);
      pulseForce();
      expDone += 2;
      waitDone(expDone);
      idleCycles(30);

      $display("[TB] random sweeps");
      for (int s = 0; s < 3; s++) begin
         randomPlan();
         applyStimulus(-1);
         waitDone(++expDone);
         idleCycles($urandom_range(1, 6));
      end

      $display("[TB] error counter saturation");
      setAllOk();
      for (int t = 0; t < ATTEMPTS; t++) begin
         plan[1][t] = RSP_NONE;
         plan[2][t] = RSP_STAT;
         plan[4][t] = RSP_ADDR;
         plan[6][t] = RSP_MSB;
      end
      applyStimulus(-1);
      waitDone(++expDone);
      idleCycles(5);

      $display("[TB] reset while waiting for a response");
      setAllOk();
      plan[0][0] = RSP_NONE;
      hs0 = hsCount;
      applyStimulus(-1);
      for (int n = 0; n < BUDGET && hsCount == hs0; n++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      rst         = 1'b1;
      resetActive = 1'b1;
      @(posedge clk); #1;
      checkOutput("mid_rst_tx_req", 32'(txReq), 32'd0);
      checkOutput("mid_rst_tx_cmd", 32'(txCmd), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_cur_idx", 32'(curIdx), 32'd0);
      checkOutput("mid_rst_done", 32'(sweepDone), 32'd0);
      checkOutput("mid_rst_comm_err", 32'(commErr), 32'd0);
      checkOutput("mid_rst_err_cnt", 32'(errCnt), 32'd0);
      cmdQ.delete();
      rspQ.delete();
      doneQ.delete();
      startQ.delete();
      mErrCnt = 0;
      idleCycles(2);
      rst = 1'b0;
      idleCycles(1);
      resetActive = 1'b0;
      idleCycles(20);
      checkOutput("no_done_after_rst", 32'(doneCount), 32'(expDone));

      $display("[TB] clean sweep after reset");
      setAllOk();
      applyStimulus(-1);
      waitDone(++expDone);
      idleCycles(10);

      checkOutput("left_cmds", 32'(cmdQ.size()), 32'd0);
      checkOutput("left_dones", 32'(doneQ.size()), 32'd0);
      checkOutput("left_starts", 32'(startQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
